bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
- Schedules resolved-branch outcomes from the EX stage into the gshare predictor's single update port (update / actually_taken / resolved_pc).
- Buffers resolutions in a small FIFO. Issues at most one update per clock and holds issue while the pipeline is stalled.
- Keeps branch and mispredict statistics counters.
- Sits between the EX-stage branch unit and the gshare predictor instance.

Parameters:
- DATA_WIDTH, 32, width of PC and of the statistics counters.
- DEPTH, 4, FIFO entries; must be a power of two, ≥ 2.
- PTR_WIDTH, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock, all state on posedge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  EX stage presents a resolved branch.
- in_ready  output  1  FIFO can accept; equals !full.
- in_pc  input  DATA_WIDTH  PC of resolved branch.
- in_taken  input  1  actual direction.
- in_pred  input  1  direction that was predicted at fetch.
- stall  input  1  pipeline stall; suppresses issue.
- clear  input  1  synchronous flush of queue and statistics.
- upd_valid  output  1  drives predictor update.
- upd_taken  output  1  drives predictor actually_taken.
- upd_pc  output  DATA_WIDTH  drives predictor resolved_pc.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- stat_branches  output  DATA_WIDTH  updates issued since reset/clear.
- stat_mispred  output  DATA_WIDTH  issued updates where taken != pred.

Behaviour:
- Reset (rstn low, asynchronous):
  - FIFO pointers and count = 0; state = IDLE.
  - upd_valid = 0, upd_taken = 0, upd_pc = 0.
  - stat_branches = 0, stat_mispred = 0.
  - empty = 1, full = 0, in_ready = 1.
- Reset mid-operation discards all queued entries; no update is issued for them.
- Enqueue: on posedge with in_valid && in_ready, {in_pc, in_taken, in_pred} is written at the write pointer. No enqueue while full, even if a dequeue happens in the same cycle.
- Issue condition: state != HOLD && !stall && !empty at posedge.
  - Head entry is popped.
  - upd_valid, upd_taken, upd_pc are registered from the head.
  - Otherwise upd_valid is registered 0; upd_pc/upd_taken hold their last values.
- Latency: an entry accepted at posedge N into an empty FIFO appears on upd_* from posedge N+1, provided stall = 0. There is no combinational bypass.
- upd_valid is high for exactly one cycle per entry. Entries issue strictly in FIFO order, at most one per cycle.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is PTR_WIDTH+1 bits, range 0..DEPTH.
- FSM (state registered):
  - IDLE (empty): non-empty && !stall -> DRAIN; non-empty && stall -> HOLD.
  - DRAIN: stall -> HOLD; count becomes 0 after pop and no push -> IDLE.
  - HOLD: !stall -> DRAIN if non-empty, else IDLE. No issue in HOLD.
  - stall is also sampled directly, so issue stops in the same cycle stall rises.
- Statistics: on each issue, stat_branches += 1; stat_mispred += 1 if entry taken != pred. Both saturate at all-ones, no wrap.
- clear (highest priority below reset):
  - At posedge, empties the FIFO and zeroes both counters.
  - upd_valid = 0 next cycle; state = IDLE.
  - An in_valid beat in the same cycle is dropped, although in_ready may have been 1.
- stall and clear together: clear wins.

Decomposition:
- Package bp_pkg: DATA_WIDTH default, FSM state encodings (IDLE = 2'd0, DRAIN = 2'd1, HOLD = 2'd2), FIFO entry width constant (DATA_WIDTH+2).
- One sub-module bp_update_fifo (DEPTH-entry circular buffer; push/pop/clear; empty/full/count).
- Scheduler FSM, output registers and counters stay in bp_update_sched.

Test Plan:
- Reset then single push (pc = 0x0000_0040, taken = 1, pred = 0, stall = 0) -> upd_valid = 1 for one cycle at the next posedge with upd_pc = 0x40, upd_taken = 1; stat_branches = 1, stat_mispred = 1.
- Push 4 entries back-to-back with stall = 1 -> full = 1, in_ready = 0, fifth push ignored, no upd_valid. Drop stall -> 4 consecutive upd_valid cycles in push order, then empty = 1, state IDLE.
- Continuous push every cycle with stall = 0 -> count stays ≤ 1, one update per cycle, pointers wrap past DEPTH with no loss or reordering over 10 entries.
- Stall asserted mid-drain (2 of 4 issued) -> upd_valid = 0 in that same cycle; release -> remaining 2 issue in order.
- clear with 3 entries queued and in_valid = 1 -> next cycle empty = 1, counters = 0, upd_valid = 0, and the same-cycle beat is not issued.
- Force stat_branches to all-ones via long run or preload -> further issues keep it at 0xFFFF_FFFF. rstn pulsed low mid-drain -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants for the branch-predictor update scheduler.
// The FIFO entry is packed as {pc, taken, pred}.
package bp_pkg;

    localparam int unsigned BP_DATA_WIDTH = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam int unsigned BP_ENTRY_WIDTH = BP_DATA_WIDTH + 2;

    function automatic int unsigned entry_width(int unsigned data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Circular buffer for resolved branches, with synchronous clear.
// Push is ignored when full and pop is ignored when empty; clr overrides both.
module bp_update_fifo #(
    parameter int unsigned WIDTH     = 34,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic                 empty,
    output logic                 full,
    output logic [PTR_WIDTH:0]   count
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wptr_q, rptr_q;
    logic [PTR_WIDTH:0]   cnt_q;
    logic                 do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PTR_WIDTH + 1)'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    // Pointers wrap naturally because DEPTH is 2**PTR_WIDTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/bp_update_sched.sv
// Queues EX-stage branch resolutions and feeds them, one per clock, into the
// gshare update port; stalls hold issue and statistics count issued updates.
module bp_update_sched
    import bp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BP_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  in_taken,
    input  logic                  in_pred,
    input  logic                  stall,
    input  logic                  clear,
    output logic                  upd_valid,
    output logic                  upd_taken,
    output logic [DATA_WIDTH-1:0] upd_pc,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] stat_branches,
    output logic [DATA_WIDTH-1:0] stat_mispred
);

    localparam int unsigned EntryW = entry_width(DATA_WIDTH);

    logic [EntryW-1:0]     head;
    logic                  fifo_empty, fifo_full;
    logic [PTR_WIDTH:0]    fifo_count, cnt_nxt;
    logic                  push, issue;
    logic [1:0]            state_q, state_d;
    logic                  upd_valid_q, upd_taken_q;
    logic [DATA_WIDTH-1:0] upd_pc_q, br_q, mp_q;

    bp_update_fifo #(
        .WIDTH     (EntryW),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clear),
        .push  (push),
        .wdata ({in_pc, in_taken, in_pred}),
        .pop   (issue),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign push     = in_valid && !fifo_full;
    assign issue    = (state_q != HOLD) && !stall && !fifo_empty && !clear;
    assign cnt_nxt  = fifo_count + {{PTR_WIDTH{1'b0}}, push} - {{PTR_WIDTH{1'b0}}, issue};
    assign in_ready = !fifo_full;
    assign empty    = fifo_empty;
    assign full     = fifo_full;

    // DRAIN is only entered with work left, so an idle-but-stalled empty queue
    // stays in IDLE and does not pay the one-cycle HOLD exit penalty.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (stall) begin
            state_d = (state_q == HOLD || !fifo_empty) ? HOLD : IDLE;
        end else begin
            state_d = (cnt_nxt == '0) ? IDLE : DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            upd_valid_q <= issue;
            if (issue) begin
                upd_pc_q    <= head[EntryW-1:2];
                upd_taken_q <= head[1];
            end
        end
    end

    // Saturating statistics; head[1] is the actual direction, head[0] the prediction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (clear) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (issue) begin
            if (br_q != '1) br_q <= br_q + 1'b1;
            if ((head[1] != head[0]) && (mp_q != '1)) mp_q <= mp_q + 1'b1;
        end
    end

    assign upd_valid     = upd_valid_q;
    assign upd_taken     = upd_taken_q;
    assign upd_pc        = upd_pc_q;
    assign stat_branches = br_q;
    assign stat_mispred  = mp_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Randomised scoreboard bench for bp_update_sched, plus an 8-bit instance
// that exercises counter saturation.
module tb_bp_update_sched;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        pred;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0, in_taken = 1'b0, in_pred = 1'b0;
    logic        stall = 1'b0, clear = 1'b0;
    logic [31:0] in_pc = '0;

    logic        in_ready, upd_valid, upd_taken, empty, full;
    logic [31:0] upd_pc, stat_branches, stat_mispred;
    logic        s_in_ready, s_upd_valid, s_upd_taken, s_empty, s_full;
    logic [7:0]  s_upd_pc, s_branches, s_mispred;

    always #5 clk = ~clk;

    bp_update_sched dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_taken      (in_taken),
        .in_pred       (in_pred),
        .stall         (stall),
        .clear         (clear),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .upd_pc        (upd_pc),
        .empty         (empty),
        .full          (full),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    bp_update_sched #(.DATA_WIDTH(8)) dut_s (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (s_in_ready),
        .in_pc         (in_pc[7:0]),
        .in_taken      (in_taken),
        .in_pred       (in_pred),
        .stall         (stall),
        .clear         (clear),
        .upd_valid     (s_upd_valid),
        .upd_taken     (s_upd_taken),
        .upd_pc        (s_upd_pc),
        .empty         (s_empty),
        .full          (s_full),
        .stat_branches (s_branches),
        .stat_mispred  (s_mispred)
    );

    // Reference model state
    ent_t        mq[$];
    ent_t        eq[$];
    bit          held;
    logic [31:0] m_pc;
    logic        m_taken;
    longint      m_br, m_mp, s_br, s_mp;
    bit          mon_on = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a branch issues when the queue has work, stall is low and the
    // scheduler was not left holding by a stall at the previous edge.
    initial begin : model
        ent_t e;
        bit   nonempty, was_full;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                mq.delete(); eq.delete();
                held = 0; m_pc = '0; m_taken = 0;
                m_br = 0; m_mp = 0; s_br = 0; s_mp = 0;
            end else if (clear) begin
                mq.delete(); eq.delete();
                held = 0;
                m_br = 0; m_mp = 0; s_br = 0; s_mp = 0;
            end else begin
                nonempty = (mq.size() != 0);
                was_full = (mq.size() == DEPTH);
                if (!held && !stall && nonempty) begin
                    e = mq.pop_front();
                    eq.push_back(e);
                    m_pc    = e.pc;
                    m_taken = e.taken;
                    if (m_br < 64'hFFFF_FFFF) m_br++;
                    if (s_br < 255) s_br++;
                    if (e.taken != e.pred) begin
                        if (m_mp < 64'hFFFF_FFFF) m_mp++;
                        if (s_mp < 255) s_mp++;
                    end
                end
                if (in_valid && !was_full) begin
                    e.pc = in_pc; e.taken = in_taken; e.pred = in_pred;
                    mq.push_back(e);
                end
                held = stall && (held || nonempty);
            end
        end
    end

    // Monitor: compares DUT outputs just after every edge (and async reset).
    initial begin : monitor
        ent_t e;
        bit   exp_v;
        wait (mon_on);
        forever begin
            @(posedge clk or negedge rstn);
            #1;
            exp_v = (eq.size() != 0);
            check("upd_valid", upd_valid, exp_v);
            check("s_upd_valid", s_upd_valid, exp_v);
            if (exp_v && upd_valid) begin
                e = eq.pop_front();
                check("upd_pc_order", upd_pc, e.pc);
                check("upd_taken_order", upd_taken, e.taken);
            end else begin
                if (exp_v) void'(eq.pop_front());
                check("upd_pc_hold", upd_pc, m_pc);
                check("upd_taken_hold", upd_taken, m_taken);
            end
            check("s_upd_pc", s_upd_pc, m_pc[7:0]);
            check("empty", empty, mq.size() == 0);
            check("full", full, mq.size() == DEPTH);
            check("in_ready", in_ready, mq.size() != DEPTH);
            check("stat_branches", stat_branches, m_br[31:0]);
            check("stat_mispred", stat_mispred, m_mp[31:0]);
            check("s_stat_branches_sat", s_branches, s_br[7:0]);
            check("s_stat_mispred_sat", s_mispred, s_mp[7:0]);
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input bit t, input bit p,
                         input bit st, input bit cl);
        @(negedge clk);
        in_valid = v; in_pc = pc; in_taken = t; in_pred = p; stall = st; clear = cl;
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, st, 0);
    endtask

    initial begin : driver
        logic [31:0] r;
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        rstn   = 1'b1;
        idle(2, 0);

        // Single push, mispredicted taken branch
        drive(1, 32'h0000_0040, 1, 0, 0, 0);
        idle(3, 0);

        // Fill under stall, fifth push dropped, then drain
        for (int i = 0; i < 5; i++) drive(1, 32'h100 + 32'(i * 4), i[0], 0, 1, 0);
        idle(3, 1);
        idle(8, 0);

        // Continuous streaming through the pointer wrap
        for (int i = 0; i < 10; i++) drive(1, 32'h200 + 32'(i * 4), i[1], i[0], 0, 0);
        idle(3, 0);

        // Stall raised mid-drain
        for (int i = 0; i < 4; i++) drive(1, 32'h300 + 32'(i * 4), 1, 1, 1, 0);
        idle(3, 0);
        idle(3, 1);
        idle(6, 0);

        // Clear with entries queued and a same-cycle beat
        for (int i = 0; i < 3; i++) drive(1, 32'h400 + 32'(i * 4), 0, 1, 1, 0);
        drive(1, 32'h0000_0bad, 1, 0, 1, 1);
        idle(4, 0);

        // Random traffic
        for (int i = 0; i < 1200; i++) begin
            r = $urandom;
            drive($urandom_range(0, 9) < 7, r, r[0], r[1] ^ r[5],
                  $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end
        idle(6, 0);

        // Long mispredicting stream saturates the 8-bit instance's counters
        for (int i = 0; i < 700; i++) begin
            r = $urandom;
            drive(1, r, r[0], ~r[0], 0, 0);
        end
        idle(4, 0);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) drive(1, 32'h500 + 32'(i * 4), 1, 0, 1, 0);
        idle(2, 0);
        #2 rstn = 1'b0;
        idle(2, 0);
        #2 rstn = 1'b1;
        drive(1, 32'h0000_0600, 0, 1, 0, 0);
        idle(5, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
